data_proc_stream: RTL and testbench
===================================

// Module: data_proc_stream
// PURPOSE
//  Parametrised streaming data-processing stage with valid/ready handshakes on both sides.
//  Each accepted beat is transformed by a runtime-selected arithmetic op (pass, wrap-add,
//  saturating add, saturating sub), then buffered in an output FIFO for downstream backpressure.
//  Reports a per-beat overflow tag, a sticky overflow flag, FIFO fill level and an output beat counter.
//  Sits between a producer and a consumer in the HDL processing chain.
// PARAMETERS
//  DATA_W     8   data path width in bits (>=2)
//  FIFO_DEPTH 4   output FIFO entries; power of 2, >=2
//  CNT_W      16  width of beat_cnt
// PORTS
//  clk        in   1                    clock; all logic on rising edge
//  rst_n      in   1                    asynchronous active-low reset
//  mode       in   2                    op select, sampled per accepted beat: 0 pass, 1 wrap-add, 2 sat-add, 3 sat-sub
//  offset     in   DATA_W               operand, sampled per accepted beat
//  in_valid   in   1                    input beat valid
//  in_ready   out  1                    input can accept
//  in_data    in   DATA_W               input data
//  out_valid  out  1                    FIFO head valid
//  out_ready  in   1                    consumer accepts head
//  out_data   out  DATA_W               processed data at FIFO head
//  out_ovf    out  1                    overflow/clamp tag of FIFO head beat
//  clr_flags  in   1                    one-cycle pulse, clears sticky_ovf
//  sticky_ovf out  1                    set once any accepted beat has out_ovf=1
//  level      out  $clog2(FIFO_DEPTH)+1 FIFO entry count, 0..FIFO_DEPTH
//  beat_cnt   out  CNT_W                number of output handshakes, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: asynchronous on rst_n low; FIFO emptied, level=0, out_valid=0, out_data=0, out_ovf=0,
//    sticky_ovf=0, beat_cnt=0, in_ready=1 once rst_n is high. Reset mid-stream discards all buffered beats.
//  Handshakes: push = in_valid & in_ready; pop = out_valid & out_ready.
//    in_ready = (level < FIFO_DEPTH) and is registered, with no combinational path from out_ready.
//    When full, the input is stalled even if a pop occurs in the same cycle.
//    out_valid = (level != 0). out_data and out_ovf hold stable while out_valid=1 and out_ready=0.
//  Latency: a beat pushed at edge N into an empty FIFO is presented with out_valid=1 after edge N (1 cycle).
//  Ordering: strict FIFO. Pointers wrap modulo FIFO_DEPTH.
//  Simultaneous push and pop with 0 < level < FIFO_DEPTH: level is unchanged and both take effect.
//  Arithmetic (DATA_W+1-bit internal sum, MAX = all ones):
//    mode 0: result = in_data, ovf = 0
//    mode 1: result = (in_data+offset) mod 2^DATA_W, ovf = carry out
//    mode 2: result = in_data+offset clamped to MAX, ovf = 1 if clamped
//    mode 3: result = in_data-offset clamped to 0, ovf = 1 if borrow
//  out_ovf is stored with each beat. sticky_ovf sets on a push with ovf=1.
//    clr_flags clears sticky_ovf; if a set and a clear occur in the same cycle, the set wins.
//  beat_cnt increments on every pop and wraps from 2^CNT_W-1 to 0.
// TESTING
//  1 rst_n low mid-traffic (level=3) -> all outputs at reset values the same cycle; level=0; in_ready=1 after release
//  2 mode=1 offset=8'h01, push 8'h41 and 8'hFF -> out 8'h42/ovf=0 then 8'h00/ovf=1; sticky_ovf=1
//  3 mode=2 offset=8'h10, push 8'hF8 -> 8'hFF/ovf=1; mode=3 offset=8'h05, push 8'h02 -> 8'h00/ovf=1; push 8'h09 -> 8'h04/ovf=0
//  4 out_ready=0, push 5 beats (depth 4) -> 4 accepted, in_ready=0 at level=4; then out_ready=1 -> 4 beats out in order, beat_cnt=4
//  5 level=2, push and pop on the same edge -> level stays 2, order preserved; at level=4 with out_ready=1 -> push refused that cycle
//  6 clr_flags pulse coincident with ovf push -> sticky_ovf stays 1; next clr_flags alone -> 0; CNT_W=2, 5 pops -> beat_cnt=1

Source files
------------

// File: rtl/data_proc_stream.sv
// rtl/data_proc_stream.sv - streaming arithmetic stage (pass/wrap-add/sat-add/sat-sub) with output FIFO
module data_proc_stream #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [1:0]                      mode,
    input  logic [DATA_W-1:0]               offset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_W-1:0]               in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_W-1:0]               out_data,
    output logic                            out_ovf,
    input  logic                            clr_flags,
    output logic                            sticky_ovf,
    output logic [$clog2(FIFO_DEPTH):0]     level,
    output logic [CNT_W-1:0]                beat_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     count;
    logic [LW-1:0]     count_nxt;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] res;
    logic              res_ovf;
    logic              push;
    logic              pop;
    logic [DATA_W:0]   head;

    always_comb begin
        sum     = {1'b0, in_data} + {1'b0, offset};
        diff    = {1'b0, in_data} - {1'b0, offset};
        res     = in_data;
        res_ovf = 1'b0;
        case (mode)
            2'd1: begin
                res     = sum[DATA_W-1:0];
                res_ovf = sum[DATA_W];
            end
            2'd2: begin
                res     = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
                res_ovf = sum[DATA_W];
            end
            2'd3: begin
                // diff MSB is the borrow out of the unsigned subtraction
                res     = diff[DATA_W] ? {DATA_W{1'b0}} : diff[DATA_W-1:0];
                res_ovf = diff[DATA_W];
            end
            default: begin
                res     = in_data;
                res_ovf = 1'b0;
            end
        endcase
    end

    assign push      = in_valid & in_ready;
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign count_nxt = count + LW'(push) - LW'(pop);
    assign head      = mem[rd_ptr];
    assign out_data  = out_valid ? head[DATA_W-1:0] : '0;
    assign out_ovf   = out_valid ? head[DATA_W] : 1'b0;
    assign level     = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {res_ovf, res};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            in_ready   <= 1'b1;
            sticky_ovf <= 1'b0;
            beat_cnt   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                beat_cnt <= beat_cnt + 1'b1;
            end
            count <= count_nxt;
            // registered from the next level so out_ready never reaches in_ready combinationally
            in_ready <= (count_nxt < LW'(FIFO_DEPTH));
            if (push && res_ovf) begin
                sticky_ovf <= 1'b1;
            end else if (clr_flags) begin
                sticky_ovf <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_data_proc_stream.sv
// tb/tb_data_proc_stream.sv - self-checking bench for data_proc_stream
module tb_data_proc_stream;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] offset = 8'd0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       out_ready = 1'b0;
    logic       clr_flags = 1'b0;

    logic        in_ready, out_valid, out_ovf, sticky_ovf;
    logic [7:0]  out_data;
    logic [2:0]  level;
    logic [15:0] beat_cnt;

    logic        b_in_ready, b_out_valid, b_out_ovf, b_sticky_ovf;
    logic [7:0]  b_out_data;
    logic [2:0]  b_level;
    logic [1:0]  b_beat_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    data_proc_stream #(.DATA_W(8), .FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .offset(offset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .clr_flags(clr_flags), .sticky_ovf(sticky_ovf),
        .level(level), .beat_cnt(beat_cnt)
    );

    data_proc_stream #(.DATA_W(8), .FIFO_DEPTH(4), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .offset(offset),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_ovf(b_out_ovf), .clr_flags(clr_flags), .sticky_ovf(b_sticky_ovf),
        .level(b_level), .beat_cnt(b_beat_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic from the op rules using plain integers
    task automatic ref_op(input logic [1:0] m, input logic [7:0] off, input logic [7:0] din,
                          output logic [7:0] d, output logic o);
        int s;
        int x;
        s = int'(din) + int'(off);
        x = int'(din) - int'(off);
        case (m)
            2'd0: begin d = din; o = 1'b0; end
            2'd1: begin d = 8'(s % 256); o = (s > 255); end
            2'd2: begin d = (s > 255) ? 8'd255 : 8'(s); o = (s > 255); end
            default: begin d = (x < 0) ? 8'd0 : 8'(x); o = (x < 0); end
        endcase
    endtask

    logic [8:0] mq[$];
    bit         m_sticky;
    int         m_cnt;
    bit         m_push, m_pop;
    logic [7:0] m_d;
    logic       m_o;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_sticky = 1'b0;
            m_cnt    = 0;
        end else begin
            m_push = in_valid && (mq.size() < 4);
            m_pop  = (mq.size() != 0) && out_ready;
            ref_op(mode, offset, in_data, m_d, m_o);
            if (m_pop) begin
                void'(mq.pop_front());
                m_cnt++;
            end
            if (m_push) mq.push_back({m_o, m_d});
            if (m_push && m_o) m_sticky = 1'b1;
            else if (clr_flags) m_sticky = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("model_out_valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("model_level", 32'(level), 32'(mq.size()));
            chk("model_in_ready", 32'(in_ready), 32'(mq.size() < 4));
            if (mq.size() != 0) begin
                chk("model_out_data", 32'(out_data), 32'(mq[0][7:0]));
                chk("model_out_ovf", 32'(out_ovf), 32'(mq[0][8]));
            end
            chk("model_sticky", 32'(sticky_ovf), 32'(m_sticky));
            chk("model_beat_cnt", 32'(beat_cnt), 32'(m_cnt % 65536));
            chk("model_beat_cnt_w2", 32'(b_beat_cnt), 32'(m_cnt % 4));
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [7:0] off;
        logic [7:0] din;
        logic [7:0] exp_d;
        logic       exp_o;
    } vec_t;

    vec_t vt[10];

    initial begin
        vt[0] = '{2'd1, 8'h01, 8'h41, 8'h42, 1'b0};
        vt[1] = '{2'd1, 8'h01, 8'hFF, 8'h00, 1'b1};
        vt[2] = '{2'd2, 8'h10, 8'hF8, 8'hFF, 1'b1};
        vt[3] = '{2'd3, 8'h05, 8'h02, 8'h00, 1'b1};
        vt[4] = '{2'd3, 8'h05, 8'h09, 8'h04, 1'b0};
        vt[5] = '{2'd0, 8'h33, 8'hA5, 8'hA5, 1'b0};
        vt[6] = '{2'd1, 8'h80, 8'h80, 8'h00, 1'b1};
        vt[7] = '{2'd2, 8'h20, 8'h10, 8'h30, 1'b0};
        vt[8] = '{2'd3, 8'hFF, 8'hFF, 8'h00, 1'b0};
        vt[9] = '{2'd1, 8'h80, 8'h7F, 8'hFF, 1'b0};

        @(negedge clk);
        do_reset();
        chk_en = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);

        // Table: each vector pushed into an empty FIFO, checked at head, then popped
        for (int i = 0; i < 10; i++) begin
            mode = vt[i].mode; offset = vt[i].off; in_data = vt[i].din;
            in_valid = 1'b1; out_ready = 1'b0;
            cyc();
            in_valid = 1'b0;
            chk("vec_out_valid", 32'(out_valid), 32'd1);
            chk("vec_out_data", 32'(out_data), 32'(vt[i].exp_d));
            chk("vec_out_ovf", 32'(out_ovf), 32'(vt[i].exp_o));
            out_ready = 1'b1;
            cyc();
            out_ready = 1'b0;
            if (i == 1) chk("vec_sticky_after_wrap", 32'(sticky_ovf), 32'd1);
        end

        // Reset mid-traffic at level 3
        do_reset();
        mode = 2'd1; offset = 8'h01; in_data = 8'hFF; in_valid = 1'b1;
        repeat (3) cyc();
        in_valid = 1'b0;
        chk("pre_rst_level", 32'(level), 32'd3);
        chk("pre_rst_sticky", 32'(sticky_ovf), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_level", 32'(level), 32'd0);
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_out_data", 32'(out_data), 32'd0);
        chk("async_rst_out_ovf", 32'(out_ovf), 32'd0);
        chk("async_rst_sticky", 32'(sticky_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Fill past depth with consumer stalled, then drain in order
        do_reset();
        mode = 2'd0;
        for (int i = 1; i <= 5; i++) begin
            in_data = 8'(i); in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        chk("full_level", 32'(level), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_data", 32'(out_data), 32'(i));
            cyc();
        end
        out_ready = 1'b0;
        chk("drain_beat_cnt", 32'(beat_cnt), 32'd4);
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Simultaneous push/pop at level 2, then refused push while full
        do_reset();
        mode = 2'd0;
        in_valid = 1'b1;
        in_data = 8'hA0; cyc();
        in_data = 8'hB0; cyc();
        in_data = 8'hC0; out_ready = 1'b1; cyc();
        chk("simul_level", 32'(level), 32'd2);
        chk("simul_head", 32'(out_data), 32'hB0);
        out_ready = 1'b0;
        in_data = 8'hD0; cyc();
        in_data = 8'hE0; cyc();
        chk("refill_level", 32'(level), 32'd4);
        in_data = 8'hF0; out_ready = 1'b1; cyc();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("full_pop_level", 32'(level), 32'd3);
        out_ready = 1'b1;
        chk("full_pop_order0", 32'(out_data), 32'hC0); cyc();
        chk("full_pop_order1", 32'(out_data), 32'hD0); cyc();
        chk("full_pop_order2", 32'(out_data), 32'hE0); cyc();
        out_ready = 1'b0;
        chk("full_pop_empty", 32'(level), 32'd0);

        // Sticky set wins over coincident clear; clear alone drops it
        do_reset();
        mode = 2'd1; offset = 8'h01; in_data = 8'hFF;
        in_valid = 1'b1; clr_flags = 1'b1; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0; clr_flags = 1'b0;
        chk("sticky_set_wins", 32'(sticky_ovf), 32'd1);
        clr_flags = 1'b1; cyc(); clr_flags = 1'b0;
        chk("sticky_cleared", 32'(sticky_ovf), 32'd0);

        // Five pops wrap the 2-bit counter to 1
        do_reset();
        mode = 2'd0; in_valid = 1'b1; out_ready = 1'b1;
        repeat (6) cyc();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("cnt16_five", 32'(beat_cnt), 32'd5);
        chk("cnt2_wrap", 32'(b_beat_cnt), 32'd1);

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            mode      = 2'($urandom_range(0, 3));
            offset    = 8'($urandom);
            in_data   = 8'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = (i % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr_flags = ($urandom_range(0, 15) == 0);
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
        cyc();
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
